// File: rtl/lcd_frame_capture.sv
// Passive RGB565+DE receiver: recovers x/y from DE edges, measures frame geometry and
// captures the top-left 8x16 cell. Define FRAME_CAPTURE_BLUE_EN to add Blue_Seen.
module lcd_frame_capture #(
    parameter int VBLANK_THRESH = 1024,
    parameter int RGB_DELAY     = 1,
    parameter int CELL_W        = 8,
    parameter int CELL_H        = 16
) (
    input  logic        PixelClk,
    input  logic        nRST,
    input  logic        LCD_DE,
    input  logic [4:0]  LCD_R,
    input  logic [5:0]  LCD_G,
    input  logic [4:0]  LCD_B,
    input  logic [3:0]  Row_Addr,
    output logic [7:0]  Row_Data,
    output logic        Frame_Valid,
    output logic [11:0] Active_Width,
    output logic [11:0] Active_Height,
    output logic        Width_Err,
    output logic        Red_Seen,
`ifdef FRAME_CAPTURE_BLUE_EN
    output logic        Blue_Seen,
`endif
    output logic [15:0] Frame_Count
);
    localparam int BW = $clog2(VBLANK_THRESH + 1);
    localparam logic [2:0] SYNC       = 3'd0;
    localparam logic [2:0] WAIT_FRAME = 3'd1;
    localparam logic [2:0] LINE       = 3'd2;
    localparam logic [2:0] HBLANK     = 3'd3;
    localparam logic [2:0] PUBLISH    = 3'd4;

    logic [2:0]       state;
    logic             de_prev;
    logic [11:0]      x_cnt, y_cnt, cur_x, x_next, ref_w;
    logic [BW-1:0]    blank_cnt;
    logic             rise, fall, blank_full, blank_hit, start_frame, do_pub;
    logic             werr_sh, red_sh;
    logic [15:0][7:0] shadow, pub;
    logic             a_de, in_cell, pix_on, pix_red;
    logic [11:0]      a_x, a_y;
    logic             unused;

    // cur_x is the coordinate of the pixel being sampled now; x_cnt holds the next one
    assign cur_x       = de_prev ? x_cnt : 12'd0;
    assign x_next      = (cur_x == 12'hFFF) ? cur_x : cur_x + 12'd1;
    assign rise        = LCD_DE & ~de_prev;
    assign fall        = ~LCD_DE & de_prev;
    assign blank_full  = (blank_cnt == BW'(VBLANK_THRESH));
    assign blank_hit   = ~LCD_DE && (blank_cnt == BW'(VBLANK_THRESH - 1));
    assign start_frame = rise && (state == WAIT_FRAME || state == PUBLISH ||
                                  (state == SYNC && blank_full));
    assign do_pub      = (state == HBLANK) && blank_hit;

    // DE/x/y history so that late-arriving RGB lines up with its own coordinates
    generate
        if (RGB_DELAY == 0) begin : g_nodly
            assign a_de = LCD_DE;
            assign a_x  = cur_x;
            assign a_y  = y_cnt;
        end else begin : g_dly
            logic [RGB_DELAY-1:0]       d_de;
            logic [RGB_DELAY-1:0][11:0] d_x, d_y;
            always_ff @(posedge PixelClk or negedge nRST) begin
                if (!nRST) begin
                    d_de <= '0;
                    d_x  <= '0;
                    d_y  <= '0;
                end else begin
                    d_de[0] <= LCD_DE;
                    d_x[0]  <= cur_x;
                    d_y[0]  <= y_cnt;
                    for (int i = 1; i < RGB_DELAY; i++) begin
                        d_de[i] <= d_de[i-1];
                        d_x[i]  <= d_x[i-1];
                        d_y[i]  <= d_y[i-1];
                    end
                end
            end
            assign a_de = d_de[RGB_DELAY-1];
            assign a_x  = d_x[RGB_DELAY-1];
            assign a_y  = d_y[RGB_DELAY-1];
        end
    endgenerate

`ifdef FRAME_CAPTURE_BLUE_EN
    logic blue_sh;
    assign pix_on = LCD_G[5] & ~LCD_B[4];
    assign unused = ^{LCD_R[3:0], LCD_G[4:0], LCD_B[3:0]};
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            blue_sh   <= 1'b0;
            Blue_Seen <= 1'b0;
        end else begin
            if (start_frame)
                blue_sh <= 1'b0;
            if (in_cell && LCD_B[4])
                blue_sh <= 1'b1;
            if (do_pub)
                Blue_Seen <= blue_sh;
        end
    end
`else
    assign pix_on = LCD_G[5];
    assign unused = ^{LCD_R[3:0], LCD_G[4:0], LCD_B};
`endif
    assign pix_red = LCD_R[4] & ~LCD_G[5];
    assign in_cell = a_de && (a_x < 12'(CELL_W)) && (a_y < 12'(CELL_H));

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            shadow <= '0;
            red_sh <= 1'b0;
        end else begin
            if (start_frame) begin
                shadow <= '0;
                red_sh <= 1'b0;
            end
            if (in_cell) begin
                shadow[a_y[3:0]][~a_x[2:0]] <= pix_on;
                if (pix_red)
                    red_sh <= 1'b1;
            end
        end
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state         <= SYNC;
            de_prev       <= 1'b0;
            x_cnt         <= '0;
            y_cnt         <= '0;
            ref_w         <= '0;
            blank_cnt     <= '0;
            werr_sh       <= 1'b0;
            pub           <= '0;
            Frame_Valid   <= 1'b0;
            Active_Width  <= '0;
            Active_Height <= '0;
            Width_Err     <= 1'b0;
            Red_Seen      <= 1'b0;
            Frame_Count   <= '0;
        end else begin
            de_prev     <= LCD_DE;
            Frame_Valid <= 1'b0;
            if (LCD_DE) begin
                x_cnt     <= x_next;
                blank_cnt <= '0;
            end else if (!blank_full) begin
                blank_cnt <= blank_cnt + 1'b1;
            end
            if (start_frame) begin
                y_cnt   <= '0;
                werr_sh <= 1'b0;
                state   <= LINE;
            end else begin
                case (state)
                    SYNC:       if (blank_full) state <= WAIT_FRAME;
                    WAIT_FRAME: ;
                    PUBLISH:    state <= WAIT_FRAME;
                    LINE: if (fall) begin
                        if (y_cnt == 12'd0)
                            ref_w <= x_cnt;
                        else if (x_cnt != ref_w)
                            werr_sh <= 1'b1;
                        y_cnt <= (y_cnt == 12'hFFF) ? y_cnt : y_cnt + 12'd1;
                        state <= HBLANK;
                    end
                    HBLANK: if (rise) begin
                        state <= LINE;
                    end else if (do_pub) begin
                        Active_Width  <= ref_w;
                        Active_Height <= y_cnt;
                        Width_Err     <= werr_sh;
                        Red_Seen      <= red_sh;
                        pub           <= shadow;
                        Frame_Valid   <= 1'b1;
                        Frame_Count   <= Frame_Count + 16'd1;
                        y_cnt         <= '0;
                        state         <= PUBLISH;
                    end
                    default:    state <= SYNC;
                endcase
            end
        end
    end

    // rows at or beyond CELL_H are never written, so they read back as zero
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST)
            Row_Data <= '0;
        else
            Row_Data <= pub[Row_Addr];
    end
endmodule

// File: tb/tb_lcd_frame_capture.sv
// Bench for lcd_frame_capture: frames are described as line lengths plus cell colours and
// the expected result set is computed from that description, then checked every cycle.
module tb_lcd_frame_capture;
    localparam int THRESH = 1024;

    logic        PixelClk = 1'b0;
    logic        nRST = 1'b0;
    logic        LCD_DE = 1'b0;
    logic [4:0]  LCD_R = '0;
    logic [5:0]  LCD_G = '0;
    logic [4:0]  LCD_B = '0;
    logic [3:0]  Row_Addr = '0;
    logic [7:0]  Row_Data;
    logic        Frame_Valid, Width_Err, Red_Seen;
    logic [11:0] Active_Width, Active_Height;
    logic [15:0] Frame_Count;
`ifdef FRAME_CAPTURE_BLUE_EN
    logic        Blue_Seen;
`endif

    lcd_frame_capture #(.VBLANK_THRESH(THRESH), .RGB_DELAY(1)) dut (
        .PixelClk(PixelClk), .nRST(nRST), .LCD_DE(LCD_DE), .LCD_R(LCD_R), .LCD_G(LCD_G),
        .LCD_B(LCD_B), .Row_Addr(Row_Addr), .Row_Data(Row_Data), .Frame_Valid(Frame_Valid),
        .Active_Width(Active_Width), .Active_Height(Active_Height), .Width_Err(Width_Err),
        .Red_Seen(Red_Seen),
`ifdef FRAME_CAPTURE_BLUE_EN
        .Blue_Seen(Blue_Seen),
`endif
        .Frame_Count(Frame_Count));

    always #5 PixelClk = ~PixelClk;

    typedef struct {
        int               w;
        int               h;
        bit               werr;
        bit               red;
        bit               blue;
        logic [15:0][7:0] rows;
    } res_t;

    int          checks = 0, errors = 0;
    int          edge_n = 0, pub_edge = -1, fv_cnt = 0, exp_fc = 0;
    res_t        exp_r, pend_r;
    logic [15:0] cellpix [16][8];
    int          line_len [64];
    int          gap_line = -1;
    bit          synced = 0, hold_addr = 0;
    int          low_run = 0;
    logic [15:0] prev_col = '0;
    logic [7:0]  font [8] = '{8'h10, 8'h30, 8'h70, 8'h10, 8'h10, 8'h10, 8'h10, 8'h7C};

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, expv, edge_n);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 4095) ? 4095 : v;
    endfunction

    function automatic void clear_res(output res_t r);
        r.w = 0; r.h = 0; r.werr = 0; r.red = 0; r.blue = 0; r.rows = '0;
    endfunction

    // Compare process: published set must match the model on every cycle
    initial begin : cmp
        logic [3:0] a;
        logic [7:0] erow;
        bit         fv_exp;
        clear_res(exp_r);
        forever begin
            @(posedge PixelClk);
            edge_n++;
            a    = Row_Addr;
            erow = exp_r.rows[a];
            fv_exp = 0;
            #1;
            if (!nRST) begin
                clear_res(exp_r);
                exp_fc   = 0;
                pub_edge = -1;
                erow     = '0;
            end else if (edge_n == pub_edge) begin
                exp_r    = pend_r;
                exp_fc   = (exp_fc + 1) & 16'hFFFF;
                pub_edge = -1;
                fv_exp   = 1;
            end
            if (Frame_Valid) fv_cnt++;
            chk("frame_valid", int'(Frame_Valid), int'(fv_exp));
            chk("active_width", int'(Active_Width), exp_r.w);
            chk("active_height", int'(Active_Height), exp_r.h);
            chk("width_err", int'(Width_Err), int'(exp_r.werr));
            chk("red_seen", int'(Red_Seen), int'(exp_r.red));
            chk("frame_count", int'(Frame_Count), exp_fc);
            chk("row_data", int'(Row_Data), int'(erow));
`ifdef FRAME_CAPTURE_BLUE_EN
            chk("blue_seen", int'(Blue_Seen), int'(exp_r.blue));
`endif
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // One cycle of stimulus; RGB trails DE by one cycle
    task automatic step(input bit de, input logic [15:0] col);
        @(negedge PixelClk);
        LCD_DE = de;
        {LCD_R, LCD_G, LCD_B} = prev_col;
        prev_col = col;
        if (!hold_addr) Row_Addr = 4'($urandom);
        if (de) low_run = 0;
        else begin
            low_run++;
            if (low_run >= THRESH) synced = 1;
        end
    endtask

    task automatic drive_frame(input int nl, input int hb, input int vb);
        res_t        r;
        bit          will;
        logic [15:0] c;
        will = synced;
        clear_res(r);
        r.w = sat(line_len[0]);
        r.h = sat(nl);
        for (int y = 0; y < nl; y++)
            if (sat(line_len[y]) != r.w) r.werr = 1;
        for (int y = 0; y < nl && y < 16; y++)
            for (int x = 0; x < line_len[y] && x < 8; x++) begin
                c = cellpix[y][x];
`ifdef FRAME_CAPTURE_BLUE_EN
                r.rows[y][7-x] = c[10] && !c[4];
                if (c[4]) r.blue = 1;
`else
                r.rows[y][7-x] = c[10];
`endif
                if (c[15] && !c[10]) r.red = 1;
            end
        for (int y = 0; y < nl; y++) begin
            for (int x = 0; x < line_len[y]; x++)
                step(1, (y < 16 && x < 8) ? cellpix[y][x] : 16'($urandom));
            if (y < nl - 1)
                repeat ((y == gap_line) ? THRESH - 1 : hb) step(0, 16'($urandom));
        end
        if (will && vb >= THRESH) begin
            pend_r   = r;
            pub_edge = edge_n + 1 + THRESH;
        end
        repeat (vb) step(0, 16'($urandom));
    endtask

    task automatic set_lens(input int nl, input int len);
        for (int i = 0; i < nl; i++) line_len[i] = len;
    endtask

    task automatic set_digit();
        logic [7:0] f;
        for (int y = 0; y < 16; y++) begin
            f = (y < 8) ? font[y] : 8'h00;
            for (int x = 0; x < 8; x++)
                cellpix[y][x] = f[7-x] ? 16'h07E0 : 16'h0000;
        end
    endtask

    task automatic fill_cell(input logic [15:0] c);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 8; x++) cellpix[y][x] = c;
    endtask

    task automatic read_row(input logic [3:0] a, output logic [7:0] d);
        hold_addr = 1;
        Row_Addr  = a;
        step(0, 16'($urandom));
        @(posedge PixelClk);
        #1;
        d = Row_Data;
        hold_addr = 0;
    endtask

    initial begin : stim
        logic [7:0]  d;
        int          nl, base, fv0;
        logic [15:0] pal [5];
        repeat (3) @(negedge PixelClk);
        chk("rst_frame_count", int'(Frame_Count), 0);
        chk("rst_width", int'(Active_Width), 0);
        chk("rst_row", int'(Row_Data), 0);
        nRST = 1'b1;

        // Frame 1 is swallowed by SYNC, frame 2 is published
        set_digit();
        set_lens(8, 16);
        repeat (5) step(0, 16'h0);
        drive_frame(8, 40, 2000);
        chk("f1_no_publish", fv_cnt, 0);
        drive_frame(8, 40, 2000);
        chk("f2_one_pulse", fv_cnt, 1);
        chk("f2_width", int'(Active_Width), 16);
        chk("f2_height", int'(Active_Height), 8);
        chk("f2_count", int'(Frame_Count), 1);
        read_row(4'd1, d);
        chk("f2_row1", int'(d), 8'b00110000);

        fill_cell(16'hF800);
        drive_frame(8, 40, 1100);
        chk("red_seen_set", int'(Red_Seen), 1);
        read_row(4'd0, d);
        chk("red_row0", int'(d), 0);
        fill_cell(16'h0000);
        drive_frame(8, 40, 1100);
        chk("red_seen_clear", int'(Red_Seen), 0);

        set_digit();
        line_len[2] = 15;
        drive_frame(8, 40, 1100);
        chk("werr_set", int'(Width_Err), 1);
        chk("werr_width", int'(Active_Width), 16);
        line_len[2] = 16;

        // Reset halfway through line 5
        for (int y = 0; y < 5; y++) begin
            repeat (16) step(1, (y < 8) ? 16'h07E0 : 16'h0);
            repeat (40) step(0, 16'h0);
        end
        repeat (8) step(1, 16'h07E0);
        nRST = 1'b0;
        LCD_DE = 1'b0;
        #1;
        chk("midrst_count", int'(Frame_Count), 0);
        chk("midrst_height", int'(Active_Height), 0);
        chk("midrst_valid", int'(Frame_Valid), 0);
        synced = 0; low_run = 0; prev_col = '0;
        repeat (2) @(negedge PixelClk);
        nRST = 1'b1;
        repeat (40) step(0, 16'h0);
        fv0 = fv_cnt;
        drive_frame(8, 40, 1100);
        chk("midrst_discard", fv_cnt - fv0, 0);
        drive_frame(8, 40, 1100);
        chk("midrst_pub_count", int'(Frame_Count), 1);
        read_row(4'd3, d);
        chk("row3", int'(d), 8'b00010000);
        read_row(4'd15, d);
        chk("row15", int'(d), 0);

        // Short h-blank and an h-blank one short of the frame threshold
        drive_frame(8, 17, 1100);
        gap_line = 3;
        drive_frame(6, 20, 1100);
        gap_line = -1;
        chk("gap_height", int'(Active_Height), 6);

`ifdef FRAME_CAPTURE_BLUE_EN
        set_digit();
        cellpix[0][2] = 16'h07FF;
        set_lens(8, 16);
        drive_frame(8, 40, 1100);
        chk("blue_seen_lit", int'(Blue_Seen), 1);
        read_row(4'd0, d);
        chk("blue_row0_bit5", int'(d[5]), 0);
`endif

        pal = '{16'h0000, 16'h07E0, 16'hF800, 16'hFFFF, 16'h001F};
        for (int f = 0; f < 6; f++) begin
            nl   = $urandom_range(1, 20);
            base = $urandom_range(1, 24);
            for (int i = 0; i < nl; i++)
                line_len[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 24) : base;
            for (int y = 0; y < 16; y++)
                for (int x = 0; x < 8; x++)
                    cellpix[y][x] = ($urandom_range(0, 5) == 5) ? 16'($urandom)
                                                              : pal[$urandom_range(0, 4)];
            drive_frame(nl, $urandom_range(2, 60), $urandom_range(THRESH, THRESH + 80));
        end

        // Overlong lines saturate the reported width
        set_lens(2, 4100);
        drive_frame(2, 10, 1100);
        chk("sat_width", int'(Active_Width), 4095);
        chk("sat_werr", int'(Width_Err), 0);

        repeat (5) step(0, 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
